rotary_position_tracker: RTL
============================

// Module: rotary_position_tracker
// PURPOSE
//  Downstream consumer of the quadrature decoder's step strobes (cnt/cnt_cw/cnt_err).
//  Keeps a bounded absolute position, counts decode errors, and hands net position
//  changes to a slower consumer over a valid/ready channel. Stalls never lose steps.
// PARAMETERS
//  POS_WIDTH    8   position register width (unsigned)
//  POS_MIN      0   lowest legal position
//  POS_MAX      99  highest legal position (POS_MIN < POS_MAX < 2**POS_WIDTH)
//  POS_INIT     0   position after reset / clear
//  WRAP         1   1: wrap MAX<->MIN; 0: saturate at bounds
//  DELTA_WIDTH  4   signed event delta width; magnitude limit DMAX = 2**(DELTA_WIDTH-1)-1
//  ERR_WIDTH    4   decode-error counter width (saturating)
// PORTS
//  i_clk        in   1            clock
//  i_rst_n      in   1            async reset, active low
//  i_clr        in   1            sync clear of position, deltas, flags, error count
//  i_cnt        in   1            one-cycle step strobe from decoder
//  i_cnt_cw     in   1            step direction, 1 = CW (+1), valid with i_cnt
//  i_cnt_err    in   1            one-cycle decode-error strobe
//  ov_pos       out  POS_WIDTH    current position, registered
//  o_at_min     out  1            ov_pos == POS_MIN
//  o_at_max     out  1            ov_pos == POS_MAX
//  o_evt_valid  out  1            event delta available
//  i_evt_ready  in   1            consumer accepts event
//  ov_evt_delta out  DELTA_WIDTH  signed net step count of event, never 0 while valid
//  o_evt_ovf    out  1            sticky: pending steps exceeded DMAX, some deltas lost
//  ov_err_cnt   out  ERR_WIDTH    saturating count of i_cnt_err strobes
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stall): ov_pos=POS_INIT, o_evt_valid=0, ov_evt_delta=0,
//    acc=0, o_evt_ovf=0, ov_err_cnt=0. Flags o_at_min/max derived from ov_pos.
//  - Step applied when i_cnt=1 and i_cnt_err=0; i_cnt with i_cnt_err in same cycle: step ignored,
//    error counted. Step effective: ov_pos updates at edge N+1 (latency 1).
//  - Bounds: WRAP=1: +1 at POS_MAX -> POS_MIN, -1 at POS_MIN -> POS_MAX. WRAP=0: step at bound
//    is dropped (no position change, no delta contribution).
//  - Event path: output register (valid, delta) + pending accumulator acc (signed, clamp +-DMAX).
//    s = +1/-1 for an applied step, else 0.
//    If !o_evt_valid or i_evt_ready: delta <= acc+s, valid <= (acc+s != 0), acc <= 0.
//    Else (stalled): delta/valid held stable; acc <= clamp(acc+s); clamp hit sets o_evt_ovf.
//    Opposite-direction steps cancel within acc; net 0 produces no event.
//  - ov_err_cnt increments per i_cnt_err, holds at 2**ERR_WIDTH-1.
//  - i_clr: priority over all inputs in that cycle; same values as reset, synchronous.
// CONFIGURATION
//  ROTARY_POS_VELOCITY_EN defined: adds output ov_step_period [15:0] = clocks between the last two
//   applied steps; free-running gap counter saturates at 16'hFFFF, cleared by reset/i_clr to FFFF.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared include lib/driver/rotary_defs.vh: direction encoding (CW=1), step sign localparams,
//  clamp helper function for signed saturation.
//  One sub-module: rotary_delta_acc (signed saturating accumulator + output register + handshake).
// TESTING (defaults unless noted; strobes applied on negedge, one cycle each)
//  1 reset low mid-stall with valid=1 -> ov_pos=0, valid=0, ovf=0, err_cnt=0 immediately.
//  2 ready=1, 3 CW strobes -> ov_pos=3, three events delta=+1, valid low after.
//  3 from 0: 1 CCW -> ov_pos=99, delta=-1; 1 CW -> ov_pos=0. WRAP=0: CCW at 0 -> pos 0, no event.
//  4 ready=0, 10 CW -> first event +1 held stable, o_evt_ovf=1; ready=1 -> +1, +7, then valid=0; pos=10.
//  5 20 err strobes -> ov_err_cnt=15, pos unchanged, no event; i_cnt+i_cnt_err together -> no step.
//  6 ready=0, CW,CCW,CW -> event +1 then +0 dropped (no 2nd event); i_clr -> pos=0, valid=0, err=0.

Source files
------------

// File: rtl/rotary_position_tracker_pkg.sv
// Shared definitions for the rotary position tracker: direction encoding,
// step signs and a signed clamp helper.
package rotary_position_tracker_pkg;

    localparam logic DIR_CW  = 1'b1;
    localparam int   STEP_UP = 1;
    localparam int   STEP_DN = -1;

    function automatic int clamp_signed(input int value, input int limit);
        if (value > limit) begin
            return limit;
        end else if (value < -limit) begin
            return -limit;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/rotary_position_tracker_delta_acc.sv
// Signed saturating step accumulator behind a valid/ready output register.
// Steps arriving while the consumer stalls are banked in acc, never dropped unless acc clamps.
module rotary_position_tracker_delta_acc
    import rotary_position_tracker_pkg::*;
#(
    parameter int DELTA_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          step_up,
    input  logic                          step_dn,
    input  logic                          ready,
    output logic                          valid,
    output logic signed [DELTA_WIDTH-1:0] delta,
    output logic                          ovf
);

    localparam int DMAX = 2**(DELTA_WIDTH-1) - 1;

    logic signed [DELTA_WIDTH-1:0] acc;
    int                            sum;
    int                            sum_clamped;
    logic                          clamp_hit;

    always_comb begin
        sum = int'(acc);
        if (step_up) begin
            sum = sum + STEP_UP;
        end else if (step_dn) begin
            sum = sum + STEP_DN;
        end
        sum_clamped = clamp_signed(sum, DMAX);
        clamp_hit   = (sum != sum_clamped);
    end

    // Output slot free: move pending net steps out; a net of zero yields no event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            delta <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
            delta <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (!valid || ready) begin
            delta <= DELTA_WIDTH'(sum_clamped);
            valid <= (sum_clamped != 0);
            acc   <= '0;
            if (clamp_hit) ovf <= 1'b1;
        end else begin
            acc <= DELTA_WIDTH'(sum_clamped);
            if (clamp_hit) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/rotary_position_tracker.sv
// Bounded absolute position tracker fed by quadrature step strobes, with decode-error count
// and a stall-tolerant delta event channel. Optional ROTARY_POS_VELOCITY_EN adds ov_step_period.
module rotary_position_tracker
    import rotary_position_tracker_pkg::*;
#(
    parameter int POS_WIDTH   = 8,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 99,
    parameter int POS_INIT    = 0,
    parameter int WRAP        = 1,
    parameter int DELTA_WIDTH = 4,
    parameter int ERR_WIDTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    input  logic                          i_cnt,
    input  logic                          i_cnt_cw,
    input  logic                          i_cnt_err,
    output logic [POS_WIDTH-1:0]          ov_pos,
    output logic                          o_at_min,
    output logic                          o_at_max,
    output logic                          o_evt_valid,
    input  logic                          i_evt_ready,
    output logic signed [DELTA_WIDTH-1:0] ov_evt_delta,
    output logic                          o_evt_ovf,
    output logic [ERR_WIDTH-1:0]          ov_err_cnt
`ifdef ROTARY_POS_VELOCITY_EN
    ,
    output logic [15:0]                   ov_step_period
`endif
);

    localparam logic [POS_WIDTH-1:0] P_MIN  = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] P_MAX  = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] P_INIT = POS_WIDTH'(POS_INIT);
    localparam logic [POS_WIDTH-1:0] P_ONE  = POS_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] E_ONE  = ERR_WIDTH'(1);

    logic [POS_WIDTH-1:0] pos_next;
    logic                 step_up;
    logic                 step_dn;

    assign o_at_min = (ov_pos == P_MIN);
    assign o_at_max = (ov_pos == P_MAX);

    // A step coinciding with a decode error is untrustworthy and ignored.
    always_comb begin
        pos_next = ov_pos;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        if (i_cnt && !i_cnt_err) begin
            if (i_cnt_cw == DIR_CW) begin
                if (!o_at_max) begin
                    pos_next = ov_pos + P_ONE;
                    step_up  = 1'b1;
                end else if (WRAP != 0) begin
                    pos_next = P_MIN;
                    step_up  = 1'b1;
                end
            end else begin
                if (!o_at_min) begin
                    pos_next = ov_pos - P_ONE;
                    step_dn  = 1'b1;
                end else if (WRAP != 0) begin
                    pos_next = P_MAX;
                    step_dn  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_pos     <= P_INIT;
            ov_err_cnt <= '0;
        end else if (i_clr) begin
            ov_pos     <= P_INIT;
            ov_err_cnt <= '0;
        end else begin
            ov_pos <= pos_next;
            if (i_cnt_err && (ov_err_cnt != '1)) begin
                ov_err_cnt <= ov_err_cnt + E_ONE;
            end
        end
    end

    rotary_position_tracker_delta_acc #(
        .DELTA_WIDTH (DELTA_WIDTH)
    ) u_delta_acc (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (i_clr),
        .step_up (step_up),
        .step_dn (step_dn),
        .ready   (i_evt_ready),
        .valid   (o_evt_valid),
        .delta   (ov_evt_delta),
        .ovf     (o_evt_ovf)
    );

`ifdef ROTARY_POS_VELOCITY_EN
    // gap_left counts down from FFFE after each step; zero means the gap has saturated.
    logic [15:0] gap_left;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_left       <= '0;
            ov_step_period <= 16'hFFFF;
        end else if (i_clr) begin
            gap_left       <= '0;
            ov_step_period <= 16'hFFFF;
        end else if (step_up || step_dn) begin
            ov_step_period <= 16'hFFFF - gap_left;
            gap_left       <= 16'hFFFE;
        end else if (gap_left != '0) begin
            gap_left <= gap_left - 16'd1;
        end
    end
`endif

endmodule
